// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS pipeline control blocks: stall bit
// positions, stall hold patterns, divide sequencer state encoding and
// the default exception vector.
package mips_ctrl_pkg;

   localparam int STALL_W     = 6;

   // Bit positions within the stall hold vector
   localparam int STALL_PC    = 0;
   localparam int STALL_IFID  = 1;
   localparam int STALL_IDEX  = 2;
   localparam int STALL_EXMEM = 3;
   localparam int STALL_WB    = 4;
   localparam int STALL_RSVD  = 5;

   // Hold patterns: every stalled stage also holds everything upstream of it
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

   // Divide sequencer states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

endpackage

// File: rtl/pipeline_stall_ctrl_div_seq_counter.sv
// div_seq_counter: 8-bit divide cycle counter for the stall controller.
// Clear has priority over load (to 1), which has priority over increment.
// tc flags that the value being written this cycle is DIV_CYCLES-1, so the
// controller can step into DIV_DONE on the same edge the count lands there.
module div_seq_counter #(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic inc,
   output logic tc
);

   localparam logic [7:0] TC_VAL = 8'(DIV_CYCLES - 1);

   logic [7:0] cnt_reg;
   logic [7:0] cnt_next;

   // Select the next count value from the control inputs
   always_comb begin
      cnt_next = cnt_reg;
      if (clr)
         cnt_next = 8'd0;
      else if (load)
         cnt_next = 8'd1;
      else if (inc)
         cnt_next = cnt_reg + 8'd1;
   end

   // Terminal count seen on the value about to be registered
   assign tc = (load || inc) && (cnt_next == TC_VAL);

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst)
         cnt_reg <= 8'd0;
      else
         cnt_reg <= cnt_next;
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall / flush controller for the 5-stage
// MIPS pipeline. Produces the per-stage hold vector for load-use hazards
// and multi-cycle divides, and flush + redirect for exceptions and ERET.
// Optional macro STALL_PERF_CNT_EN adds a saturating stall-cycle counter;
// without it stall_cycles is tied to zero.
module pipeline_stall_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         id_stall_req,
   input  logic         ex_div_start,
   input  logic         exc_valid,
   input  logic         eret_valid,
   input  logic [31:0]  epc_in,
   output logic [5:0]   stall,
   output logic         flush,
   output logic [31:0]  new_pc,
   output logic         div_busy,
   output logic         div_done,
   output logic         div_abort,
   output logic [31:0]  stall_cycles
);

   div_state_e state_reg;
   div_state_e state_next;

   logic               redirect;
   logic               cnt_clr;
   logic               cnt_load;
   logic               cnt_inc;
   logic               cnt_tc;

   logic [STALL_W-1:0] stall_raw;
   logic               flush_raw;
   logic [31:0]        new_pc_raw;
   logic               abort_raw;

   assign redirect = exc_valid || eret_valid;

   // Counter controls depend only on state and inputs, never on tc
   assign cnt_load = (state_reg == IDLE) && ex_div_start && !redirect;
   assign cnt_inc  = (state_reg == DIV_RUN) && !redirect;
   assign cnt_clr  = redirect || (state_reg == DIV_DONE);

   div_seq_counter #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .load (cnt_load),
      .inc  (cnt_inc),
      .tc   (cnt_tc)
   );

   // State register; reset drops any divide in flight without a pulse
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state: redirect wins, otherwise walk the divide sequence
   always_comb begin
      state_next = state_reg;
      if (redirect) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:     if (ex_div_start) state_next = cnt_tc ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt_tc) state_next = DIV_DONE;
            DIV_DONE: state_next = IDLE;
            default:  state_next = IDLE;
         endcase
      end
   end

   // Outputs: exception > ERET > divide hold > load-use hold
   always_comb begin
      stall_raw  = STALL_NONE;
      flush_raw  = 1'b0;
      new_pc_raw = 32'd0;
      abort_raw  = 1'b0;
      if (exc_valid) begin
         flush_raw  = 1'b1;
         new_pc_raw = EXC_VECTOR;
         abort_raw  = (state_reg == DIV_RUN);
      end else if (eret_valid) begin
         flush_raw  = 1'b1;
         new_pc_raw = epc_in;
         abort_raw  = (state_reg == DIV_RUN);
      end else begin
         case (state_reg)
            IDLE: begin
               if (ex_div_start)
                  stall_raw = STALL_EX;
               else if (id_stall_req)
                  stall_raw = STALL_ID;
            end
            DIV_RUN:  stall_raw = STALL_EX;
            DIV_DONE: stall_raw = id_stall_req ? STALL_ID : STALL_NONE;
            default:  stall_raw = STALL_NONE;
         endcase
      end
   end

   // Every output reads zero while reset is held
   genvar gi;
   generate
      for (gi = 0; gi < STALL_W; gi++) begin : g_stall_gate
         assign stall[gi] = stall_raw[gi] & ~rst;
      end
   endgenerate

   assign flush     = flush_raw & ~rst;
   assign new_pc    = rst ? 32'd0 : new_pc_raw;
   assign div_busy  = (state_reg == DIV_RUN)  && !rst;
   assign div_done  = (state_reg == DIV_DONE) && !rst;
   assign div_abort = abort_raw & ~rst;

`ifdef STALL_PERF_CNT_EN
   logic [31:0] perf_cnt_reg;
   logic [31:0] perf_cnt_next;

   // Count stalled cycles, holding at all-ones rather than wrapping
   always_comb begin
      perf_cnt_next = perf_cnt_reg;
      if ((stall != STALL_NONE) && (perf_cnt_reg != 32'hFFFF_FFFF))
         perf_cnt_next = perf_cnt_reg + 32'd1;
   end

   // Counter register, cleared only by reset (flush leaves it alone)
   always_ff @(posedge clk) begin
      if (rst)
         perf_cnt_reg <= 32'd0;
      else
         perf_cnt_reg <= perf_cnt_next;
   end

   assign stall_cycles = rst ? 32'd0 : perf_cnt_reg;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl with DIV_CYCLES=4.
// Expected outputs come from a cycle model and are queued when each
// stimulus cycle is driven, then popped and compared against the DUT.
module tb_pipeline_stall_ctrl;

   localparam int          DC  = 4;
   localparam logic [31:0] VEC = 32'h0000_0020;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_stall_req = 1'b0;
   logic        ex_div_start = 1'b0;
   logic        exc_valid = 1'b0;
   logic        eret_valid = 1'b0;
   logic [31:0] epc_in = 32'd0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        div_busy;
   logic        div_done;
   logic        div_abort;
   logic [31:0] stall_cycles;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(
      .DIV_CYCLES (DC),
      .EXC_VECTOR (VEC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_stall_req (id_stall_req),
      .ex_div_start (ex_div_start),
      .exc_valid    (exc_valid),
      .eret_valid   (eret_valid),
      .epc_in       (epc_in),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .div_abort    (div_abort),
      .stall_cycles (stall_cycles)
   );

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        busy;
      logic        done;
      logic        abort;
      logic [31:0] perf;
   } obs_t;

   obs_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   // Cycle model: 0 idle, 1 running, 2 done
   int          m_state = 0;
   int          m_cnt   = 0;
   logic [31:0] m_perf  = 32'd0;

   function automatic obs_t observe();
      obs_t o;
      o = {stall, flush, new_pc, div_busy, div_done, div_abort, stall_cycles};
      return o;
   endfunction

   // Drive one cycle of stimulus, queue the expected outputs, advance model
   task automatic step(input logic r, input logic req, input logic ds,
                       input logic ex, input logic er, input logic [31:0] epc);
      obs_t e;
      @(negedge clk);
      rst = r; id_stall_req = req; ex_div_start = ds;
      exc_valid = ex; eret_valid = er; epc_in = epc;
      e = '0;
      if (!r) begin
         e.busy = (m_state == 1);
         e.done = (m_state == 2);
         if (ex || er) begin
            e.flush  = 1'b1;
            e.new_pc = ex ? VEC : epc;
            e.abort  = (m_state == 1);
         end else if (m_state == 0) begin
            e.stall = ds ? 6'b001111 : (req ? 6'b000111 : 6'b000000);
         end else if (m_state == 1) begin
            e.stall = 6'b001111;
         end else begin
            e.stall = req ? 6'b000111 : 6'b000000;
         end
`ifdef STALL_PERF_CNT_EN
         e.perf = m_perf;
`endif
      end
      sb.push_back(e);
      if (r) begin
         m_state = 0; m_cnt = 0; m_perf = 32'd0;
      end else begin
         if (e.stall != 6'd0 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
         if (ex || er) begin
            m_state = 0; m_cnt = 0;
         end else if (m_state == 0) begin
            if (ds) begin
               m_cnt = 1;
               m_state = (m_cnt == DC - 1) ? 2 : 1;
            end
         end else if (m_state == 1) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DC - 1) m_state = 2;
         end else begin
            m_state = 0; m_cnt = 0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      obs_t o, e;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL reset[%0d]: got %h required %h", i, o, e);
         end
         n_cmp++;
         if (o !== '0) begin
            n_err++; $display("FAIL reset_zero[%0d]: got %h required 0", i, o);
         end
      end
   endtask

   task automatic test_load_use();
      obs_t o, e;
      logic [4:0] tbl [0:3];
      tbl = '{5'b00000, 5'b01000, 5'b00000, 5'b01000};
      for (int i = 0; i < 4; i++) begin
         step(tbl[i][4], tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0], 32'd0);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL load_use[%0d]: got %h required %h", i, o, e);
         end
         n_cmp++;
         if (stall !== (tbl[i][3] ? 6'b000111 : 6'b000000) || flush !== 1'b0 || div_busy !== 1'b0) begin
            n_err++; $display("FAIL load_use_stall[%0d]: got stall=%b flush=%b busy=%b required stall=%b flush=0 busy=0",
                              i, stall, flush, div_busy, tbl[i][3] ? 6'b000111 : 6'b000000);
         end
      end
   endtask

   task automatic test_divide();
      obs_t o, e;
      logic [5:0] x_stall [0:5];
      logic       x_busy  [0:5];
      logic       x_done  [0:5];
      x_stall = '{6'b001111, 6'b001111, 6'b001111, 6'b000000, 6'b000000, 6'b000000};
      x_busy  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      x_done  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, (i < 4), 1'b0, 1'b0, 32'd0);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL divide[%0d]: got %h required %h", i, o, e);
         end
         n_cmp++;
         if (stall !== x_stall[i] || div_busy !== x_busy[i] || div_done !== x_done[i]) begin
            n_err++; $display("FAIL divide_timing[%0d]: got stall=%b busy=%b done=%b required stall=%b busy=%b done=%b",
                              i, stall, div_busy, div_done, x_stall[i], x_busy[i], x_done[i]);
         end
      end
   endtask

   task automatic test_exc_mid_div();
      obs_t o, e;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, (i < 3), (i == 2), 1'b0, 32'd0);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL exc_mid_div[%0d]: got %h required %h", i, o, e);
         end
         if (i == 2) begin
            n_cmp++;
            if (flush !== 1'b1 || new_pc !== 32'h0000_0020 || div_abort !== 1'b1 || stall !== 6'd0) begin
               n_err++; $display("FAIL exc_abort: got flush=%b pc=%h abort=%b stall=%b required 1 00000020 1 000000",
                                 flush, new_pc, div_abort, stall);
            end
         end else if (i > 2) begin
            n_cmp++;
            if (div_done !== 1'b0 || div_busy !== 1'b0 || div_abort !== 1'b0) begin
               n_err++; $display("FAIL exc_after[%0d]: got done=%b busy=%b abort=%b required 0 0 0",
                                 i, div_done, div_busy, div_abort);
            end
         end
      end
   endtask

   task automatic test_eret();
      obs_t o, e;
      logic [4:0] tbl [0:5];
      tbl = '{5'b00001, 5'b00011, 5'b00000, 5'b00100, 5'b00001, 5'b00000};
      for (int i = 0; i < 6; i++) begin
         step(tbl[i][4], tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0], 32'h0040_1000);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL eret[%0d]: got %h required %h", i, o, e);
         end
         if (i == 0 || i == 1) begin
            n_cmp++;
            if (new_pc !== (i == 0 ? 32'h0040_1000 : 32'h0000_0020) || flush !== 1'b1) begin
               n_err++; $display("FAIL eret_pc[%0d]: got pc=%h flush=%b required pc=%h flush=1",
                                 i, new_pc, flush, (i == 0 ? 32'h0040_1000 : 32'h0000_0020));
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      obs_t o, e;
      logic [5:0] x_stall [0:4];
      x_stall = '{6'b001111, 6'b001111, 6'b001111, 6'b000111, 6'b000000};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, (i < 4), (i < 4), 1'b0, 1'b0, 32'd0);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL simultaneous[%0d]: got %h required %h", i, o, e);
         end
         n_cmp++;
         if (stall !== x_stall[i] || div_done !== (i == 3)) begin
            n_err++; $display("FAIL simul_stall[%0d]: got stall=%b done=%b required stall=%b done=%b",
                              i, stall, div_done, x_stall[i], (i == 3));
         end
      end
   endtask

   task automatic test_reset_mid_div();
      obs_t o, e;
      for (int i = 0; i < 6; i++) begin
         step((i == 2), 1'b0, (i < 2), 1'b0, 1'b0, 32'd0);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL reset_mid_div[%0d]: got %h required %h", i, o, e);
         end
         if (i >= 2) begin
            n_cmp++;
            if (stall !== 6'd0 || div_busy !== 1'b0 || div_done !== 1'b0 || div_abort !== 1'b0 || flush !== 1'b0) begin
               n_err++; $display("FAIL reset_idle[%0d]: got stall=%b busy=%b done=%b abort=%b flush=%b required all 0",
                                 i, stall, div_busy, div_done, div_abort, flush);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin
         n_err++; $display("FAIL b2b_reset: got %h required %h", o, e);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, (i < 8), 1'b0, 1'b0, 32'd0);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL back_to_back[%0d]: got %h required %h", i, o, e);
         end
         n_cmp++;
         if (div_done !== (i == 3 || i == 7)) begin
            n_err++; $display("FAIL b2b_done[%0d]: got %b required %b", i, div_done, (i == 3 || i == 7));
         end
      end
      n_cmp++;
`ifdef STALL_PERF_CNT_EN
      if (stall_cycles !== 32'd6) begin
         n_err++; $display("FAIL perf_count: got %0d required 6", stall_cycles);
      end
`else
      if (stall_cycles !== 32'd0) begin
         n_err++; $display("FAIL perf_count: got %0d required 0", stall_cycles);
      end
`endif
   endtask

   task automatic test_random();
      obs_t o, e;
      logic r, req, ds, ex, er;
      for (int i = 0; i < 300; i++) begin
         r   = ($urandom_range(49) == 0);
         req = ($urandom_range(2) == 0);
         ds  = ($urandom_range(2) == 0);
         ex  = ($urandom_range(19) == 0);
         er  = ($urandom_range(19) == 0);
         step(r, req, ds, ex, er, $urandom);
         o = observe(); e = sb.pop_front(); n_cmp++;
         if (o !== e) begin
            n_err++; $display("FAIL random[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_divide();
      test_exc_mid_div();
      test_eret();
      test_simultaneous();
      test_reset_mid_div();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
